// File: rtl/tag_lookup_unit.sv
// Set-associative tag lookup with LRU victim choice, fill and sequential flush.
// Optional stored tag parity is compiled in with `define TAG_PARITY_EN.
module tag_lookup_unit #(
  parameter int INDEX_BITS = 3,
  parameter int ADDR_BITS  = 5,
  parameter int WAYS       = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_BITS-1:0] req_addr,
  output logic                 rsp_valid,
  output logic                 rsp_hit,
  output logic                 rsp_way,
  input  logic                 fill_valid,
  input  logic [ADDR_BITS-1:0] fill_addr,
  input  logic                 flush_req,
  output logic                 busy,
  output logic                 flush_done,
  output logic                 parity_err
);

  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS;
  localparam int SETS     = 1 << INDEX_BITS;
  localparam logic [INDEX_BITS-1:0] CNT_LAST = INDEX_BITS'(SETS - 1);
  localparam logic [INDEX_BITS-1:0] CNT_ONE  = INDEX_BITS'(1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  logic [0:0]            r_state;
  logic [INDEX_BITS-1:0] r_cnt;
  logic [SETS-1:0]       r_valid [WAYS];
  logic [TAG_BITS-1:0]   r_tag   [WAYS][SETS];
  logic [SETS-1:0]       r_lru;
  logic                  r_rsp_valid;
  logic                  r_rsp_hit;
  logic                  r_rsp_way;
  logic                  r_flush_done;

  logic [INDEX_BITS-1:0] w_rd_idx;
  logic [TAG_BITS-1:0]   w_rd_tag;
  logic [INDEX_BITS-1:0] w_fl_idx;
  logic [TAG_BITS-1:0]   w_fl_tag;
  logic                  w_acc;
  logic [WAYS-1:0]       w_hit_vec;
  logic                  w_hit;
  logic                  w_hit_way;
  logic                  w_rd_vic;
  logic                  w_fl_vic;
  logic                  w_perr;

  assign w_rd_idx = req_addr[INDEX_BITS-1:0];
  assign w_rd_tag = req_addr[ADDR_BITS-1:INDEX_BITS];
  assign w_fl_idx = fill_addr[INDEX_BITS-1:0];
  assign w_fl_tag = fill_addr[ADDR_BITS-1:INDEX_BITS];

  assign busy       = (r_state == S_FLUSH);
  assign req_ready  = !busy;
  assign w_acc      = req_valid && req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_hit    = r_rsp_hit;
  assign rsp_way    = r_rsp_way;
  assign flush_done = r_flush_done;

  always_comb begin
    w_hit_vec = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_hit_vec[w] = r_valid[w][w_rd_idx] &&
                     (r_tag[w][w_rd_idx] == w_rd_tag);
    end
  end

  assign w_hit     = |w_hit_vec;
  assign w_hit_way = (WAYS == 2) ? !w_hit_vec[0] : 1'b0;

  // Victim: first invalid way, otherwise the way the LRU bit names.
  generate
    if (WAYS == 2) begin : g_two_way
      assign w_rd_vic = !r_valid[0][w_rd_idx] ? 1'b0 :
                        !r_valid[1][w_rd_idx] ? 1'b1 :
                        r_lru[w_rd_idx];
      assign w_fl_vic = !r_valid[0][w_fl_idx] ? 1'b0 :
                        !r_valid[1][w_fl_idx] ? 1'b1 :
                        r_lru[w_fl_idx];
    end else begin : g_one_way
      assign w_rd_vic = 1'b0;
      assign w_fl_vic = 1'b0;
    end
  endgenerate

`ifdef TAG_PARITY_EN
  logic [SETS-1:0] r_par [WAYS];
  logic            r_perr;

  always_comb begin
    w_perr = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w][w_rd_idx] &&
          ((^r_tag[w][w_rd_idx]) != r_par[w][w_rd_idx]))
        w_perr = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perr <= 1'b0;
      for (int w = 0; w < WAYS; w++) r_par[w] <= '0;
    end else begin
      r_perr <= w_acc && w_perr;
      if (r_state == S_IDLE && fill_valid)
        r_par[w_fl_vic][w_fl_idx] <= ^w_fl_tag;
    end
  end

  assign parity_err = r_perr;
`else
  assign w_perr     = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_lru        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_hit    <= 1'b0;
      r_rsp_way    <= 1'b0;
      r_flush_done <= 1'b0;
      for (int w = 0; w < WAYS; w++) begin
        r_valid[w] <= '0;
        for (int s = 0; s < SETS; s++) r_tag[w][s] <= '0;
      end
    end else begin
      r_rsp_valid  <= w_acc;
      r_rsp_hit    <= w_acc && w_hit && !w_perr;
      r_rsp_way    <= w_acc && (w_hit ? w_hit_way : w_rd_vic);
      r_flush_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_acc && w_hit && !w_perr)
            r_lru[w_rd_idx] <= !w_hit_way;
          // Issued after the hit update so a same-set fill owns LRU.
          if (fill_valid) begin
            r_valid[w_fl_vic][w_fl_idx] <= 1'b1;
            r_tag[w_fl_vic][w_fl_idx]   <= w_fl_tag;
            r_lru[w_fl_idx]             <= !w_fl_vic;
          end
          if (flush_req) begin
            r_state <= S_FLUSH;
            r_cnt   <= '0;
          end
        end
        S_FLUSH: begin
          for (int w = 0; w < WAYS; w++) r_valid[w][r_cnt] <= 1'b0;
          r_lru[r_cnt] <= 1'b0;
          r_cnt        <= r_cnt + CNT_ONE;
          if (r_cnt == CNT_LAST) begin
            r_state      <= S_IDLE;
            r_flush_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tag_lookup_unit.sv
// Bench for tag_lookup_unit: vector table feeding a response scoreboard,
// plus flush, reset-during-flush and optional parity sequences.
module tb_tag_lookup_unit;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [4:0] req_addr;
  logic       rsp_valid;
  logic       rsp_hit;
  logic       rsp_way;
  logic       fill_valid;
  logic [4:0] fill_addr;
  logic       flush_req;
  logic       busy;
  logic       flush_done;
  logic       parity_err;

  tag_lookup_unit #(
    .INDEX_BITS(3),
    .ADDR_BITS (5),
    .WAYS      (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_hit   (rsp_hit),
    .rsp_way   (rsp_way),
    .fill_valid(fill_valid),
    .fill_addr (fill_addr),
    .flush_req (flush_req),
    .busy      (busy),
    .flush_done(flush_done),
    .parity_err(parity_err)
  );

  typedef struct {
    logic       rv;
    logic [4:0] ra;
    logic       fv;
    logic [4:0] fa;
    logic       hit;
    logic       way;
    logic       perr;
  } vec_t;

  typedef struct {
    int   due;
    logic hit;
    logic way;
    logic perr;
  } exp_t;

  vec_t vt[$];
  exp_t sbq[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (sbq.size() != 0 && sbq[0].due < cyc) begin
        void'(sbq.pop_front());
        chk("rsp_timeout", 0, 1);
      end
      if (sbq.size() != 0 && sbq[0].due == cyc) begin
        exp_t e;
        e = sbq.pop_front();
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_hit", rsp_hit, e.hit);
        chk("rsp_way", rsp_way, e.way);
        chk("parity_err", parity_err, e.perr);
      end else if (rsp_valid) begin
        chk("spurious_rsp", rsp_valid, 0);
      end
    end
  end

  task automatic drive(input vec_t v);
    req_valid  = v.rv;
    req_addr   = v.ra;
    fill_valid = v.fv;
    fill_addr  = v.fa;
    if (v.rv) sbq.push_back('{cyc + 1, v.hit, v.way, v.perr});
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    fill_valid = 1'b0;
  endtask

  task automatic look(input logic [4:0] a, input logic h,
                      input logic w, input logic p);
    drive('{1'b1, a, 1'b0, 5'd0, h, w, p});
  endtask

  task automatic fill(input logic [4:0] a);
    drive('{1'b0, 5'd0, 1'b1, a, 1'b0, 1'b0, 1'b0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    fill_valid = 1'b0;
    fill_addr  = '0;
    flush_req  = 1'b0;

    vt.push_back('{1, 5'b10_011, 0, 5'b00_000, 0, 0, 0});
    vt.push_back('{0, 5'b00_000, 1, 5'b10_011, 0, 0, 0});
    vt.push_back('{1, 5'b10_011, 0, 5'b00_000, 1, 0, 0});
    vt.push_back('{1, 5'b01_011, 0, 5'b00_000, 0, 1, 0});
    vt.push_back('{0, 5'b00_000, 1, 5'b01_011, 0, 0, 0});
    vt.push_back('{1, 5'b10_011, 0, 5'b00_000, 1, 0, 0});
    vt.push_back('{0, 5'b00_000, 1, 5'b11_011, 0, 0, 0});
    vt.push_back('{1, 5'b01_011, 0, 5'b00_000, 0, 0, 0});
    vt.push_back('{1, 5'b10_011, 0, 5'b00_000, 1, 0, 0});
    vt.push_back('{1, 5'b11_011, 0, 5'b00_000, 1, 1, 0});
    vt.push_back('{1, 5'b11_101, 1, 5'b11_101, 0, 0, 0});
    vt.push_back('{1, 5'b11_101, 0, 5'b00_000, 1, 0, 0});
    vt.push_back('{1, 5'b11_101, 1, 5'b00_101, 1, 0, 0});
    vt.push_back('{0, 5'b00_000, 1, 5'b01_101, 0, 0, 0});
    vt.push_back('{1, 5'b11_101, 0, 5'b00_000, 0, 1, 0});
    vt.push_back('{1, 5'b00_101, 0, 5'b00_000, 1, 1, 0});
    vt.push_back('{1, 5'b01_101, 0, 5'b00_000, 1, 0, 0});
    vt.push_back('{1, 5'b10_011, 1, 5'b10_000, 1, 0, 0});
    vt.push_back('{0, 5'b00_000, 1, 5'b10_000, 0, 0, 0});
    vt.push_back('{1, 5'b10_000, 0, 5'b00_000, 1, 0, 0});

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_hit", rsp_hit, 0);
    chk("rst_rsp_way", rsp_way, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_parity_err", parity_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vt.size(); i++) drive(vt[i]);

    // Flush with a lookup accepted in the same cycle as flush_req.
    flush_req = 1'b1;
    look(5'b10_011, 1'b1, 1'b0, 1'b0);
    flush_req  = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 5'b10_011;
    fill_valid = 1'b1;
    fill_addr  = 5'b10_110;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("flush_busy", busy, 1);
      chk("flush_ready", req_ready, 0);
      chk("flush_done_early", flush_done, 0);
    end
    req_valid  = 1'b0;
    fill_valid = 1'b0;
    @(negedge clk);
    chk("flush_done_pulse", flush_done, 1);
    chk("flush_busy_end", busy, 0);
    chk("flush_ready_end", req_ready, 1);
    @(negedge clk);
    chk("flush_done_single", flush_done, 0);

    look(5'b10_011, 1'b0, 1'b0, 1'b0);
    look(5'b11_011, 1'b0, 1'b0, 1'b0);
    look(5'b11_101, 1'b0, 1'b0, 1'b0);
    look(5'b10_000, 1'b0, 1'b0, 1'b0);
    look(5'b10_110, 1'b0, 1'b0, 1'b0);

    // Reset four cycles into a flush.
    fill(5'b01_111);
    look(5'b01_111, 1'b1, 1'b0, 1'b0);
    flush_req = 1'b1;
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("mid_flush_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_flush_done", flush_done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_flush_done", flush_done, 0);
      chk("idle_busy", busy, 0);
    end
    look(5'b01_111, 1'b0, 1'b0, 1'b0);

`ifdef TAG_PARITY_EN
    fill(5'b10_100);
    look(5'b10_100, 1'b1, 1'b0, 1'b0);
    force dut.r_tag[0][4] = 2'b11;
    look(5'b11_100, 1'b0, 1'b0, 1'b1);
    release dut.r_tag[0][4];
`endif

    repeat (4) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tag_lookup_unit.md
TAG_LOOKUP_UNIT -- requirements
Module: tag_lookup_unit

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 3: set index width; the block has 2**INDEX_BITS sets.
REQ-002 SHALL have parameter ADDR_BITS, default 5: lookup address width; TAG_BITS = ADDR_BITS-INDEX_BITS.
REQ-003 SHALL have parameter WAYS, default 2: associativity; only 1 or 2 are legal.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 SHALL have ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  lookup request
- req_ready  out  1  lookup accepted when high with req_valid
- req_addr  in  ADDR_BITS  {tag,index}
- rsp_valid  out  1  lookup result strobe
- rsp_hit  out  1  hit flag
- rsp_way  out  1  hit way, or victim way on a miss
- fill_valid  in  1  install tag
- fill_addr  in  ADDR_BITS  {tag,index} to install
- flush_req  in  1  invalidate-all pulse
- busy  out  1  flush in progress
- flush_done  out  1  one-cycle pulse at the end of a flush
- parity_err  out  1  parity fault on the response; driven 0 without TAG_PARITY_EN

Function
REQ-006 Each set SHALL hold WAYS entries of {valid, tag} and one LRU bit when WAYS=2.
REQ-007 A lookup SHALL be accepted when req_valid && req_ready; rsp_valid, rsp_hit and rsp_way SHALL follow exactly 1 cycle later and stay high for 1 cycle only.
REQ-008 A hit SHALL require the entry's valid bit set and its stored tag equal to the request tag; rsp_way SHALL report the matching way, lowest way on a double match.
REQ-009 Victim selection SHALL be: way 0 if invalid, else way 1 if invalid, else the LRU way. With WAYS=1 the victim is always way 0.
REQ-010 On a miss, rsp_way SHALL report the victim for the set.
REQ-011 A hit SHALL set that set's LRU bit to point at the other way.
REQ-012 fill_valid SHALL write {1, fill tag} into the victim of fill_addr's set on the same rising edge, and set LRU to the other way.
REQ-013 A lookup and a fill in the same cycle SHALL both proceed; the lookup SHALL see pre-fill contents (read-before-write).
REQ-014 When a lookup and a fill hit the same set in the same cycle, the fill's LRU update SHALL win.
REQ-015 The FSM SHALL have two states:
- IDLE: flush_req -> FLUSH with set counter = 0.
- FLUSH: clear every valid bit and the LRU bit of set[counter] each cycle; after the last set -> IDLE with flush_done pulsed.
- A flush takes exactly 2**INDEX_BITS cycles.
REQ-016 While in FLUSH:
- busy SHALL be 1 and req_ready SHALL be 0;
- fill_valid and flush_req SHALL be ignored.
REQ-017 req_ready SHALL equal !busy.
REQ-018 A lookup accepted in the cycle flush_req arrives SHALL complete normally against pre-flush contents.

Reset
REQ-019 Asserting rst_n low SHALL asynchronously:
- clear all valid and LRU bits;
- force the FSM to IDLE and the counter to 0;
- drive rsp_valid, rsp_hit, rsp_way, busy, flush_done and parity_err to 0.
REQ-020 A reset during FLUSH SHALL abort the flush with no flush_done pulse; tag contents are don't-care.

Configuration
REQ-021 With macro TAG_PARITY_EN defined:
- each entry SHALL store an even-parity bit over its tag, written on fill;
- a lookup whose candidate entries include a valid entry with bad parity SHALL force rsp_hit=0 and parity_err=1 with the response.
REQ-022 Without TAG_PARITY_EN, no parity storage SHALL exist and parity_err SHALL be tied to 0.

Verification
REQ-023 Reset, then look up 5'b10_011 -> rsp_valid=1 one cycle later, rsp_hit=0, rsp_way=0.
REQ-024 Fill 5'b10_011, then look up 5'b10_011 -> rsp_hit=1, rsp_way=0; look up 5'b01_011 -> rsp_hit=0, rsp_way=1.
REQ-025 Fill tags 2'b10 and 2'b01 in set 3, hit 2'b10, then fill 2'b11 -> 2'b01 is evicted and looking up 2'b10 still hits.
REQ-026 Fill and lookup of 5'b11_101 in the same cycle on an empty set -> miss; the next lookup of 5'b11_101 hits.
REQ-027 Pulse flush_req -> busy=1 and req_ready=0 for 8 cycles, then flush_done=1 for 1 cycle; every prior tag then misses; a fill during the flush is dropped.
REQ-028 With TAG_PARITY_EN, corrupt a stored tag bit via force, then look it up -> rsp_hit=0, parity_err=1; reset mid-flush at cycle 4 -> busy=0 immediately and no flush_done.
